// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: producer end of the result-wakeup (common data bus) interface.
//
// Gathers finished results from the ALU, branch unit and load/store buffer. It
// broadcasts up to two results per cycle on two registered ready channels. Results
// that cannot go out this cycle wait in a circular FIFO and leave oldest first.
// Only the LSB source can be back-pressured. The ALU and BRU are always accepted.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   rdy                       global ready; low freezes all state and ignores inputs
//   has_misbranch             flush: empties the FIFO, drops this cycle's inputs
//   alu_* / bru_*             always-accepted result sources (valid, robnum, data)
//   lsb_valid/robnum/data     back-pressured result source
//   lsb_ready                 LSB result taken when lsb_valid && lsb_ready
//   has_rd_ready_1/2          channel valids (channel 2 valid implies channel 1 valid)
//   ready_robnum_1/2, ready_data_1/2   channel payloads, held while invalid

module cdb_broadcaster #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ROB_W  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              has_misbranch,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_robnum,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              bru_valid,
    input  logic [ROB_W-1:0]  bru_robnum,
    input  logic [DATA_W-1:0] bru_data,
    input  logic              lsb_valid,
    input  logic [ROB_W-1:0]  lsb_robnum,
    input  logic [DATA_W-1:0] lsb_data,
    output logic              lsb_ready,
    output logic              has_rd_ready_1,
    output logic [ROB_W-1:0]  ready_robnum_1,
    output logic [DATA_W-1:0] ready_data_1,
    output logic              has_rd_ready_2,
    output logic [ROB_W-1:0]  ready_robnum_2,
    output logic [DATA_W-1:0] ready_data_2
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef struct packed {
        logic [ROB_W-1:0]  robnum;
        logic [DATA_W-1:0] data;
    } result_t;

    // State
    result_t       mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          v1_q, v2_q;
    result_t       r1_q, r2_q;

    // Next-state helpers
    logic          advance;
    logic          lsb_take;
    logic [2:0]    src_v;
    result_t       src_res [3];
    result_t       in_res [3];     // this cycle's accepted inputs, compacted in priority order
    logic [1:0]    in_cnt;
    logic [1:0]    pop;
    logic [1:0]    slots;          // channel slots left over for this cycle's inputs
    logic [1:0]    n_push;
    logic [2:0]    idx;
    result_t       push_res [3];
    result_t       fifo0, fifo1;
    logic          ch1_v, ch2_v;
    result_t       ch1_r, ch2_r;

    // Two ALU/BRU results always fit while count <= DEPTH. LSB only fits below DEPTH.
    assign advance   = rdy && !rst && !has_misbranch;
    assign lsb_ready = advance && (count_q < DepthC);
    assign lsb_take  = lsb_valid && lsb_ready;

    assign fifo0 = mem_q[head_q];
    assign fifo1 = mem_q[head_q + AW'(1)];

    always_comb begin
        src_v      = {lsb_take, bru_valid, alu_valid};
        src_res[0] = '{robnum: alu_robnum, data: alu_data};
        src_res[1] = '{robnum: bru_robnum, data: bru_data};
        src_res[2] = '{robnum: lsb_robnum, data: lsb_data};

        in_cnt = 2'd0;
        for (int i = 0; i < 3; i++) begin
            in_res[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            if (src_v[i]) begin
                in_res[in_cnt] = src_res[i];
                in_cnt         = in_cnt + 2'd1;
            end
        end

        pop    = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        slots  = 2'd2 - pop;
        n_push = (in_cnt > slots) ? (in_cnt - slots) : 2'd0;

        // Inputs that did not get a channel slot, in list order, go to the tail
        idx = 3'd0;
        for (int p = 0; p < 3; p++) begin
            idx         = 3'(slots) + 3'(p);
            push_res[p] = (idx < 3'd3) ? in_res[idx[1:0]] : '0;
        end

        // Queue entries always go out before this cycle's inputs
        ch1_v = 1'b0;
        ch1_r = fifo0;
        ch2_v = 1'b0;
        ch2_r = fifo1;
        case (pop)
            2'd2: begin
                ch1_v = 1'b1;
                ch2_v = 1'b1;
            end
            2'd1: begin
                ch1_v = 1'b1;
                ch2_v = (in_cnt != 2'd0);
                ch2_r = in_res[0];
            end
            default: begin
                ch1_v = (in_cnt != 2'd0);
                ch1_r = in_res[0];
                ch2_v = (in_cnt >= 2'd2);
                ch2_r = in_res[1];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            r1_q    <= '0;
            r2_q    <= '0;
        end else if (has_misbranch) begin
            // Payloads keep their old values. Only the valids and the queue are cleared.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else if (rdy) begin
            head_q  <= head_q + AW'(pop);
            tail_q  <= tail_q + AW'(n_push);
            count_q <= count_q - CW'(pop) + CW'(n_push);
            v1_q    <= ch1_v;
            v2_q    <= ch2_v;
            if (ch1_v) begin
                r1_q <= ch1_r;
            end
            if (ch2_v) begin
                r2_q <= ch2_r;
            end
        end
    end

    // Storage needs no reset. Occupancy is tracked only by head/tail/count.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int p = 0; p < 3; p++) begin
                if (2'(p) < n_push) begin
                    mem_q[tail_q + AW'(p)] <= push_res[p];
                end
            end
        end
    end

    assign has_rd_ready_1 = v1_q;
    assign ready_robnum_1 = r1_q.robnum;
    assign ready_data_1   = r1_q.data;
    assign has_rd_ready_2 = v2_q;
    assign ready_robnum_2 = r2_q.robnum;
    assign ready_data_2   = r2_q.data;

    count_le_depth: assert property (@(posedge clk) disable iff (rst) count_q <= DepthC);

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer end of the result-wakeup interface: collects finished results from the ALU, branch unit (BRU) and load/store buffer (LSB).
- Broadcasts up to two results per cycle on the two ready channels (has_rd_ready_1/2, ready_robnum_1/2, ready_data_1/2) consumed by the reservation station, LSB and ROB.
- Excess results wait in an internal FIFO, oldest first.
- Only the LSB source is back-pressured; the ALU and BRU never stall.

Parameters:
DEPTH, 8, overflow queue entries (power of two, >=4)
ROB_W, 4, ROB index width
DATA_W, 32, result data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; low = freeze all state
has_misbranch  in  1  flush request
alu_valid  in  1  ALU result valid this cycle
alu_robnum  in  ROB_W  ALU destination ROB index
alu_data  in  DATA_W  ALU result
bru_valid  in  1  BRU result valid
bru_robnum  in  ROB_W  BRU destination ROB index
bru_data  in  DATA_W  BRU result (link value)
lsb_valid  in  1  LSB result offered
lsb_robnum  in  ROB_W  LSB destination ROB index
lsb_data  in  DATA_W  load data
lsb_ready  out  1  LSB result accepted when lsb_valid && lsb_ready
has_rd_ready_1  out  1  channel 1 valid
ready_robnum_1  out  ROB_W  channel 1 ROB index
ready_data_1  out  DATA_W  channel 1 data
has_rd_ready_2  out  1  channel 2 valid
ready_robnum_2  out  ROB_W  channel 2 ROB index
ready_data_2  out  DATA_W  channel 2 data

Behaviour:
- State: circular FIFO (head, tail, count of width log2(DEPTH)+1), plus registered channel outputs.
- lsb_ready is combinational: rdy && !rst && !has_misbranch && count < DEPTH.
- Per rdy cycle, build an ordered candidate list:
  - FIFO entries, head first;
  - then this cycle's inputs in the order alu, bru, lsb (lsb only if accepted).
- Output assignment:
  - First candidate goes to channel 1, second to channel 2; registered, visible next cycle.
  - Remaining candidates are pushed at tail in list order.
  - Popped entries are removed from head, pop count = min(2, count).
- Latency: with an empty FIFO, an input at cycle N appears on a channel at cycle N+1.
- Channel rules:
  - Channel 2 valid implies channel 1 valid.
  - With no candidates, both valids are 0.
  - robnum/data keep their old values when invalid.
- Capacity proof: ALU+BRU (2 results) always fit while count <= DEPTH; LSB fits iff count < DEPTH. Overflow is therefore impossible. Verification asserts count <= DEPTH.
- No de-duplication or reordering of inputs: the same robnum from two sources is broadcast twice.
- head/tail wrap modulo DEPTH.
- rdy low:
  - All registers hold, including output valids, so a channel stays asserted.
  - Inputs are ignored; lsb_ready = 0.
- has_misbranch (when not rst), regardless of rdy:
  - Next cycle: both valids 0, FIFO emptied (head=tail=count=0).
  - Inputs present in the flush cycle are dropped.
- rst: same as flush.
  - Reset values: has_rd_ready_1/2 = 0, ready_robnum_1/2 = 0, ready_data_1/2 = 0; head = tail = count = 0.
  - rst has priority over has_misbranch and rdy.

Test Plan:
- Reset, then ALU-only input: alu_valid=1, robnum=3, data=0x11 at cycle N -> cycle N+1 has_rd_ready_1=1, ready_robnum_1=3, ready_data_1=0x11, has_rd_ready_2=0; cycle N+2 both valids 0.
- All three sources valid on an empty FIFO (ALU rob1/0xA, BRU rob2/0xB, LSB rob3/0xC):
  - N+1: ch1=rob1, ch2=rob2;
  - N+2: ch1=rob3, ch2 invalid;
  - count returns to 0.
- Saturation: drive all three sources every cycle for 10 cycles.
  - count rises by 1 per cycle; lsb_ready drops the cycle count reaches 8.
  - With LSB then held unaccepted, count stays 8 while ALU+BRU continue.
  - Broadcast robnum order exactly matches input order (queue first, then alu, bru, lsb).
- Flush: with count=5 and ALU valid, assert has_misbranch one cycle -> next cycle both valids 0, count=0, ALU result of flush cycle never broadcast; lsb_ready=0 during the flush cycle.
- rdy stall: while ch1 shows rob7, drop rdy for 3 cycles with ALU inputs toggling -> ch1 stays rob7 valid, count unchanged, inputs ignored; resumes normal order when rdy returns.
- Wrap: push/pop more than 2*DEPTH entries through the FIFO -> no loss or duplication; a scoreboard of sent vs. broadcast robnums matches.
